// File: rtl/pattern_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package pattern_det_pkg;

  localparam logic [31:0] DEF_PATTERN     = 32'h0000_000D;
  localparam int          DEF_LEN         = 4;
  localparam logic        DEF_OVERLAP     = 1'b1;
  localparam logic        MODE_OVERLAP    = 1'b1;
  localparam logic        MODE_NONOVERLAP = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                    r_cnt <= '0;
    else if (clr_i)                r_cnt <= '0;
    else if (inc_i && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pattern_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap / non-overlap
// match modes and a saturating match counter.
module pattern_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = pattern_det_pkg::clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = pattern_det_pkg::DEF_PATTERN[MAX_LEN-1:0],
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(pattern_det_pkg::DEF_LEN),
  parameter logic               DEF_OVERLAP = pattern_det_pkg::DEF_OVERLAP,
  parameter int                 COUNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               d_i,
  input  logic               d_valid_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cnt_clr_i,
  output logic               pattern_detected_o,
  output logic [COUNT_W-1:0] match_count_o,
  output logic               cfg_err_o
);

  import pattern_det_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist, r_pat;
  logic [LEN_W-1:0]   r_fill, r_len;
  logic               r_ovl, r_det, r_err;

  logic [MAX_LEN-1:0] w_hist_n, w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_accept, w_match, w_cfg_ok;

  // A load in the same cycle as a data bit discards the bit.
  assign w_accept = d_valid_i & ~cfg_load_i;
  assign w_hist_n = {r_hist[MAX_LEN-2:0], d_i};
  assign w_fill_n = (r_fill == MAX_LEN_L) ? r_fill : r_fill + 1'b1;
  // len_q >= 1 always, so the shift stays below MAX_LEN.
  assign w_mask   = {MAX_LEN{1'b1}} >> (MAX_LEN_L - r_len);
  assign w_match  = w_accept && (w_fill_n >= r_len) &&
                    (((w_hist_n ^ r_pat) & w_mask) == '0);
  assign w_cfg_ok = (cfg_len_i != '0) && (cfg_len_i <= MAX_LEN_L);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PATTERN;
      r_len  <= DEF_LEN;
      r_ovl  <= DEF_OVERLAP;
      r_det  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_det <= w_match;
      r_err <= cfg_load_i & ~w_cfg_ok;
      if (cfg_load_i) begin
        if (w_cfg_ok) begin
          r_pat  <= cfg_pattern_i;
          r_len  <= cfg_len_i;
          r_ovl  <= cfg_overlap_i;
          r_hist <= '0;
          r_fill <= '0;
        end
      end else if (w_accept) begin
        r_hist <= w_hist_n;
        r_fill <= (w_match && r_ovl == MODE_NONOVERLAP) ? '0 : w_fill_n;
      end
    end
  end

  sat_counter #(.W(COUNT_W)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_match),
    .clr_i (cnt_clr_i),
    .cnt_o (match_count_o)
  );

  assign pattern_detected_o = r_det;
  assign cfg_err_o          = r_err;

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Directed plus randomized bench for pattern_detector_prog against a
// queue-based reference model of the matching rules.
module tb_pattern_detector_prog;

  localparam int ML  = 8;
  localparam int LW  = 4;
  localparam int CW  = 2;
  localparam int CMX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          d_i, d_valid_i, cfg_load_i, cfg_overlap_i, cnt_clr_i;
  logic [ML-1:0] cfg_pattern_i;
  logic [LW-1:0] cfg_len_i;
  logic          pattern_detected_o, cfg_err_o;
  logic [CW-1:0] match_count_o;

  pattern_detector_prog #(.MAX_LEN(ML), .COUNT_W(CW)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .d_i                (d_i),
    .d_valid_i          (d_valid_i),
    .cfg_load_i         (cfg_load_i),
    .cfg_pattern_i      (cfg_pattern_i),
    .cfg_len_i          (cfg_len_i),
    .cfg_overlap_i      (cfg_overlap_i),
    .cnt_clr_i          (cnt_clr_i),
    .pattern_detected_o (pattern_detected_o),
    .match_count_o      (match_count_o),
    .cfg_err_o          (cfg_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits since the last clear, newest at the back.
  bit          q[$];
  logic [ML-1:0] m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt;

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_1101;
    m_len = 4;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit d, input bit v, input bit ld, input logic [ML-1:0] pat,
                      input int len, input bit ovl, input bit clr, input string tag);
    bit e_det, e_err;
    e_det = 1'b0;
    e_err = 1'b0;
    d_i = d; d_valid_i = v; cfg_load_i = ld; cfg_pattern_i = pat;
    cfg_len_i = LW'(len); cfg_overlap_i = ovl; cnt_clr_i = clr;
    if (ld) begin
      if (len >= 1 && len <= ML) begin
        m_pat = pat; m_len = len; m_ovl = ovl; q.delete();
      end else e_err = 1'b1;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > ML) void'(q.pop_front());
      if (q.size() >= m_len) begin
        e_det = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size()-1-i] != m_pat[i]) e_det = 1'b0;
      end
      if (e_det && !m_ovl) q.delete();
    end
    if (clr) m_cnt = 0;
    else if (e_det && m_cnt < CMX) m_cnt++;
    @(posedge clk);
    #1;
    chk({tag, ".det"}, CW'(pattern_detected_o), CW'(e_det));
    chk({tag, ".cnt"}, match_count_o, CW'(m_cnt));
    chk({tag, ".err"}, CW'(cfg_err_o), CW'(e_err));
    d_valid_i = 1'b0; cfg_load_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  task automatic bits(input logic [15:0] s, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(s[i], 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [ML-1:0] pat, input int len, input bit ovl, input string tag);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, tag);
  endtask

  initial begin
    rst_i = 1'b0; d_i = 0; d_valid_i = 0; cfg_load_i = 0; cfg_pattern_i = '0;
    cfg_len_i = '0; cfg_overlap_i = 0; cnt_clr_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.det", CW'(pattern_detected_o), '0);
    chk("rst.cnt", match_count_o, '0);
    chk("rst.err", CW'(cfg_err_o), '0);
    rst_i = 1'b1;

    // Defaults: 1101 overlapping
    bits(16'b1101101, 7, "t1");
    chk("t1.total", match_count_o, 2'd2);

    load(8'b1101, 4, 1'b0, "t2.ld");
    bits(16'b1101101, 7, "t2");

    load(8'b111, 3, 1'b1, "t3a.ld");
    bits(16'b11111, 5, "t3a");
    load(8'b111, 3, 1'b0, "t3b.ld");
    bits(16'b11111, 5, "t3b");

    load(8'b1101, 4, 1'b1, "t4.ld");
    load(8'hFF, 0, 1'b0, "t4.len0");
    load(8'hFF, 9, 1'b0, "t4.len9");
    bits(16'b1101, 4, "t4");
    // Load colliding with a data bit: bit dropped, load wins
    step(1'b1, 1'b1, 1'b1, 8'b1, 1, 1'b1, 1'b0, "t4.coll");

    // len 1 pattern "1": every 1 matches; counter saturates at 3
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, "t5.clr0");
    bits(16'b111111, 6, "t5");
    step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1, "t5.clr");

    // Reset mid-stream with a partial 1101 in history
    load(8'b1101, 4, 1'b1, "t6.ld");
    bits(16'b1101, 4, "t6a");
    step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, "t6.b1");
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, "t6.gap");
    step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, "t6.b2");
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, "t6.gap2");
    step(1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, "t6.b3");
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("t6.async.det", CW'(pattern_detected_o), '0);
    chk("t6.async.cnt", match_count_o, '0);
    chk("t6.async.err", CW'(cfg_err_o), '0);
    #2 rst_i = 1'b1;
    bits(16'b1, 1, "t6.post");
    bits(16'b1101, 4, "t6b");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit ld, clr;
      int len;
      ld  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 29) == 0);
      len = $urandom_range(0, 10);
      if ($urandom_range(0, 3) != 0 && len > 0 && len <= 3) len = len;
      step(1'($urandom), 1'($urandom_range(0, 3) != 0), ld, ML'($urandom), len,
           1'($urandom), clr, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector_prog.md
Name: pattern_detector_prog

Overview:
Runtime-programmable serial pattern detector. It is the parametrised successor of the fixed 4-bit Mealy detector.
- Matches a pattern of 1..MAX_LEN bits, loaded at run time, against a qualified serial bit stream.
- Supports overlapping and non-overlapping match modes.
- Keeps a saturating match counter.
- Sits on the serial data path after the bit-recovery logic and feeds the status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 2..32)
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)
DEF_PATTERN, 8'b0000_1101, pattern after reset, right-aligned
DEF_LEN, 4, pattern length after reset
DEF_OVERLAP, 1, match mode after reset (1 = overlapping)
COUNT_W, 16, match counter width

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-low reset
d_i  input  1  serial data bit
d_valid_i  input  1  d_i is sampled on this cycle
cfg_load_i  input  1  single-cycle strobe: latch cfg_* fields
cfg_pattern_i  input  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit received
cfg_len_i  input  LEN_W  new pattern length
cfg_overlap_i  input  1  new match mode
cnt_clr_i  input  1  synchronous clear of the match counter
pattern_detected_o  output  1  registered one-cycle match pulse
match_count_o  output  COUNT_W  saturating count of matches
cfg_err_o  output  1  one-cycle pulse: cfg_load_i was rejected

Behaviour:
- One clock domain. Reset is asynchronous, active-low on rst_i, and is the only asynchronous input.
- Reset values:
  - pattern_detected_o=0, match_count_o=0, cfg_err_o=0.
  - hist=0, fill=0.
  - pat_q=DEF_PATTERN, len_q=DEF_LEN, ovl_q=DEF_OVERLAP.
- State:
  - hist: MAX_LEN-bit shift register.
  - fill: valid-bit count, 0..MAX_LEN.
  - pat_q, len_q, ovl_q: configuration registers.
- Accepted bit (d_valid_i=1, cfg_load_i=0):
  - hist_n = {hist[MAX_LEN-2:0], d_i}.
  - fill_n = min(fill+1, MAX_LEN).
- Match condition: fill_n >= len_q and hist_n[len_q-1:0] == pat_q[len_q-1:0]. Bits above len_q are masked.
- Latency: pattern_detected_o goes high on the clock edge that accepts the last pattern bit. It is high for exactly one cycle, then returns to 0 unless the next accepted bit also matches.
- When d_valid_i=0: hist and fill hold, pattern_detected_o=0. Gaps between bits do not break a match.
- Overlap mode (ovl_q=1): hist and fill are kept after a match. A suffix of the match can start the next match.
- Non-overlap mode (ovl_q=0): on a match, fill is forced to 0. Bits of the matched pattern are never reused.
- Configuration load:
  - Accepted if 1 <= cfg_len_i <= MAX_LEN. Then pat_q, len_q and ovl_q are updated, and hist and fill are cleared on the same edge.
  - Rejected otherwise: the configuration is unchanged and cfg_err_o pulses for 1 cycle.
- cfg_load_i and d_valid_i in the same cycle: the load wins. The data bit is discarded and pattern_detected_o=0. This holds whether the load is accepted or rejected.
- Counter:
  - Increments by 1 on each match.
  - Saturates at 2^COUNT_W-1 and never wraps.
  - cnt_clr_i forces the counter to 0.
  - cnt_clr_i in the same cycle as a match: the clear wins and the counter reads 0. pattern_detected_o still pulses.
- Reset mid-stream: all state returns to reset values immediately. No partial match survives reset.
- fill never exceeds MAX_LEN.
- len_q=1 is legal: every accepted bit equal to pat_q[0] matches.

Decomposition:
- Package pattern_det_pkg holds:
  - Default constants: DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
  - A clog2 helper function for LEN_W.
  - Mode constants: MODE_OVERLAP=1, MODE_NONOVERLAP=0.
- One sub-module, sat_counter: parameter W; inputs inc_i, clr_i (clr wins); output cnt_o (saturating). It is instantiated for match_count_o.
- Shift/compare and configuration logic stay in the top level.

Test Plan:
1. Reset defaults (1101, overlap); stream 1,1,0,1,1,0,1 -> pulses after bit 4 and bit 7; match_count_o=2.
2. Load 1101 with overlap=0; same stream -> single pulse after bit 4; match_count_o=1.
3. Load 3'b111, len 3, overlap=1; stream 1,1,1,1,1 -> pulses after bits 3, 4 and 5. Repeat with overlap=0 -> pulse only after bit 3.
4. cfg_load_i with cfg_len_i=0, then with 9 (MAX_LEN=8) -> cfg_err_o pulses each time; the previous pattern still detects 1101.
5. COUNT_W=2, six matches, then cnt_clr_i asserted in the same cycle as a 7th match -> count reads 3 after the 3rd match, holds at 3 through the 6th, reads 0 after the clear; pattern_detected_o pulses on the 7th match.
6. Stream 1,1,0 with d_valid_i gaps, then rst_i low between clock edges -> all outputs 0 without waiting for a clock edge; after release, bit 1 gives no pulse; then 1,1,0,1 pulses once.
